noc_mux: RTL
============

# noc_mux

Parametrised N-to-1 network-on-chip multiplexer that lets several cores share one memory interface on the fabric clock. It accepts request packets from `N_PORTS` upstream ports with round-robin arbitration and stamps each with its source port ID. It registers the winner onto a single downstream request channel. Responses coming back from the memory side are steered by destination ID into per-port response FIFOs. It sits in the SoC top between the core instances and the memory interface, replacing the single point-to-point core/memory link.

## Interface
Parameters:
- `N_PORTS`, default 2: number of upstream ports, legal range 1..16.
- `RSP_DEPTH`, default 4: entries per response FIFO; must be a power of 2, ≥2.

Ports:
- `fclk`, input, 1: fabric clock; the only clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `up_req_valid`, input, N_PORTS: per-port request valid.
- `up_req_ready`, output, N_PORTS: per-port request accepted.
- `up_req`, input, N_PORTS × `noc_pkt_t`: per-port request packets.
- `dn_req_valid`, output, 1: downstream request valid.
- `dn_req_ready`, input, 1: downstream accepts the request.
- `dn_req`, output, `noc_pkt_t`: downstream request packet.
- `dn_rsp_valid`, input, 1: response valid from memory.
- `dn_rsp_ready`, output, 1: the mux can take the response.
- `dn_rsp`, input, `noc_pkt_t`: response packet.
- `up_rsp_valid`, output, N_PORTS: per-port response valid.
- `up_rsp_ready`, input, N_PORTS: per-port response consumed.
- `up_rsp`, output, N_PORTS × `noc_pkt_t`: per-port response packets.
- `rsp_err`, output, 1: sticky flag meaning a response was misrouted.

## Operation
- Handshake rule on every channel: a transfer happens when valid && ready on a `fclk` rising edge. Once valid is high, it holds and the packet stays stable until the transfer.
- Request arbitration:
  - The grant goes to the first requesting port at or after `rr_ptr`, wrapping modulo N_PORTS.
  - `up_req_ready[i]` = grant[i] && (!dn_req_valid || dn_req_ready). At most one bit is high.
  - On acceptance the packet is loaded into the output register with `src` overwritten by the port index. Other fields pass through unchanged.
  - After each acceptance, `rr_ptr` ← grant index + 1, wrapping to 0 after N_PORTS−1.
  - When no port requests, `rr_ptr` holds.
- Output register: a single stage. Load and drain in the same cycle is supported, which gives full throughput of 1 packet per cycle.
- Response routing:
  - `dn_rsp.dst` selects the target FIFO.
  - `dn_rsp_ready` = dst < N_PORTS ? !full[dst] : 1.
  - A response with dst ≥ N_PORTS is accepted and discarded, and it sets `rsp_err`.
  - Each FIFO presents its head on `up_rsp[i]`. `up_rsp_valid[i]` = !empty[i].
- Full/empty:
  - A FIFO accepts a write while it is full only if the same-cycle read frees a slot, i.e. `up_rsp_ready[i]` && valid.
  - Reading an empty FIFO has no effect.
  - Read and write pointers wrap modulo RSP_DEPTH; a count of log2(RSP_DEPTH)+1 bits distinguishes full from empty.
- Reset:
  - During reset, all outputs are 0 and both ready outputs are held 0.
  - `rr_ptr` = 0, all FIFOs are emptied, and `rsp_err` = 0.
  - Reset mid-transfer drops the in-flight packet; no partial state survives.

## Timing
- Request latency: accepted at edge N, `dn_req_valid` is high from after edge N.
- Response latency: written at edge N, `up_rsp_valid[dst]` is high from after edge N. FIFO data comes from the registered storage.
- `up_req_ready` and `dn_rsp_ready` are combinational from inputs and registered state. `dn_req_*` and `up_rsp_*` are register-driven, with no combinational path from inputs.
- Simultaneous events:
  - A new grant and an `rr_ptr` update occur in the same cycle as the downstream drain.
  - A FIFO read and write in the same cycle leave the count unchanged.

## Configuration
- `NOC_MUX_PERF_EN` defined:
  - Adds an output `perf_grants`, N_PORTS × 32 bits, holding per-port accepted-request counters.
  - Counters are 0 on reset, increment on each acceptance, and wrap at 2^32.
- `NOC_MUX_PERF_EN` undefined: the port and the counters are absent, and the logic is otherwise identical.

## Structure
- The shared package holds:
  - `noc_pkt_t`, a packed struct with fields `dst` [3:0], `src` [3:0], `addr` [31:0], `data` [127:0] and `we`.
  - `NOC_ID_W` = 4 and `NOC_MAX_PORTS` = 16.
- Sub-module `noc_rsp_fifo`: parameterised by depth, with one instance per port. Arbitration stays inline in `noc_mux`.

## Test plan
- N_PORTS=2, both ports holding valid for 4 cycles, `dn_req_ready`=1 → grants alternate 0,1,0,1, and `dn_req.src` follows the same order with 1-cycle latency.
- Port 1 sends addr 0x100 with src field 0xF → downstream sees src=1, with addr and data unchanged.
- `dn_req_ready`=0 for 3 cycles while port 0 is valid → `dn_req` is stable, `up_req_ready`=0 after the first accept, and there is no loss or duplication.
- RSP_DEPTH=4, `up_rsp_ready[0]`=0, 5 responses to dst=0 → 4 accepted, `dn_rsp_ready`=0 on the 5th. Raising ready drains them in order, with the 5th accepted in the same cycle as the first read.
- Response with dst=7 while N_PORTS=2 → it is consumed with `dn_rsp_ready`=1, no `up_rsp_valid` is raised, and `rsp_err`=1 until `rst`.
- `rst` asserted with `dn_req_valid`=1 and FIFOs non-empty → all valids are 0 on the next cycle. After release, the first grant goes to port 0, and with `NOC_MUX_PERF_EN` the counters read 0.

Source files
------------

// File: rtl/noc_mux_pkg.sv
// Shared types and constants for the NoC request/response multiplexer.
package noc_mux_pkg;

    localparam int NOC_ID_W      = 4;
    localparam int NOC_MAX_PORTS = 16;

    typedef struct packed {
        logic [NOC_ID_W-1:0] dst;
        logic [NOC_ID_W-1:0] src;
        logic [31:0]         addr;
        logic [127:0]        data;
        logic                we;
    } noc_pkt_t;

endpackage

// File: rtl/noc_rsp_fifo.sv
// Per-port response FIFO: registered storage, head presented directly on rd_dat.
// Write-to-valid latency 1 cycle; a full FIFO still accepts a write when the same cycle pops.
// Backpressure: wr_rdy drops when full and not being read; held low during reset.
module noc_rsp_fifo
    import noc_mux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_vld,
    input  noc_pkt_t wr_dat,
    output logic     wr_rdy,
    output logic     rd_vld,
    input  logic     rd_rdy,
    output noc_pkt_t rd_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    noc_pkt_t      mem_q [DEPTH];
    logic          empty, full, do_rd, do_wr;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        do_rd    = rd_rdy && !empty;
        wr_rdy   = !rst && (!full || do_rd);
        do_wr    = wr_vld && wr_rdy;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
        rd_vld   = !empty;
        rd_dat   = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/noc_mux.sv
// N-to-1 request mux with round-robin grant and src stamping; responses steered to per-port FIFOs by dst.
// Latency: request accepted at edge N is on dn_req from after N; response written at N is on up_rsp from after N.
// Backpressure: single output register loads while empty or draining; dn_rsp_ready follows the target FIFO. Option: NOC_MUX_PERF_EN.
module noc_mux
    import noc_mux_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                     fclk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       up_req_valid,
    output logic [N_PORTS-1:0]       up_req_ready,
    input  noc_pkt_t [N_PORTS-1:0]   up_req,
    output logic                     dn_req_valid,
    input  logic                     dn_req_ready,
    output noc_pkt_t                 dn_req,
    input  logic                     dn_rsp_valid,
    output logic                     dn_rsp_ready,
    input  noc_pkt_t                 dn_rsp,
    output logic [N_PORTS-1:0]       up_rsp_valid,
    input  logic [N_PORTS-1:0]       up_rsp_ready,
    output noc_pkt_t [N_PORTS-1:0]   up_rsp,
    output logic                     rsp_err
`ifdef NOC_MUX_PERF_EN
    ,
    output logic [N_PORTS-1:0][31:0] perf_grants
`endif
);

    logic [NOC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                dn_vld_q, dn_vld_d;
    noc_pkt_t            dn_req_q, dn_req_d;
    logic                rsp_err_q, rsp_err_d;

    int                  idx;
    int                  gnt_idx;
    logic                gnt_vld;
    noc_pkt_t            gnt_pkt;
    logic                load;
    logic                rsp_in_range;
    logic                rsp_rdy;
    logic [N_PORTS-1:0]  fifo_wr_vld;
    logic [N_PORTS-1:0]  fifo_wr_rdy;

    // First requester at or after rr_ptr, scanning with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 0;
        idx     = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            for (int i = 0; i < N_PORTS; i++) begin
                if (!gnt_vld && (i == idx) && up_req_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = i;
                end
            end
        end
    end

    always_comb begin
        gnt_pkt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (i == gnt_idx) gnt_pkt = up_req[i];
        end
        gnt_pkt.src = NOC_ID_W'(gnt_idx);

        load = !rst && gnt_vld && (!dn_vld_q || dn_req_ready);
        for (int i = 0; i < N_PORTS; i++) begin
            up_req_ready[i] = load && (i == gnt_idx);
        end

        rr_ptr_d = rr_ptr_q;
        if (load) rr_ptr_d = (gnt_idx == N_PORTS - 1) ? '0 : NOC_ID_W'(gnt_idx + 1);

        dn_vld_d = dn_vld_q;
        dn_req_d = dn_req_q;
        if (load) begin
            dn_vld_d = 1'b1;
            dn_req_d = gnt_pkt;
        end else if (dn_req_ready) begin
            dn_vld_d = 1'b0;
        end
    end

    // Out-of-range destinations are swallowed and flagged rather than stalling the memory side.
    always_comb begin
        rsp_in_range = (int'(dn_rsp.dst) < N_PORTS);
        rsp_rdy      = 1'b1;
        for (int i = 0; i < N_PORTS; i++) begin
            fifo_wr_vld[i] = dn_rsp_valid && (int'(dn_rsp.dst) == i);
            if (int'(dn_rsp.dst) == i) rsp_rdy = fifo_wr_rdy[i];
        end
        dn_rsp_ready = !rst && rsp_rdy;
        rsp_err_d    = rsp_err_q || (dn_rsp_valid && dn_rsp_ready && !rsp_in_range);
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            dn_vld_q  <= 1'b0;
            dn_req_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            dn_vld_q  <= dn_vld_d;
            dn_req_q  <= dn_req_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign dn_req_valid = dn_vld_q;
    assign dn_req       = dn_req_q;
    assign rsp_err      = rsp_err_q;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_rsp
        noc_rsp_fifo #(
            .DEPTH(RSP_DEPTH)
        ) u_fifo (
            .clk    (fclk),
            .rst    (rst),
            .wr_vld (fifo_wr_vld[g]),
            .wr_dat (dn_rsp),
            .wr_rdy (fifo_wr_rdy[g]),
            .rd_vld (up_rsp_valid[g]),
            .rd_rdy (up_rsp_ready[g]),
            .rd_dat (up_rsp[g])
        );
    end

`ifdef NOC_MUX_PERF_EN
    logic [N_PORTS-1:0][31:0] perf_q;

    always_ff @(posedge fclk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (up_req_ready[i]) perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    assign perf_grants = perf_q;
`endif

endmodule
